// File: rtl/spi_slave_regs.sv
// SPI mode-0 register-bank responder, fully oversampled in clk_clk (no logic on SCLK).
// Optional burst address auto-increment: define SPI_SLAVE_AUTOINC_EN.
module spi_slave_regs #(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_ss_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic                  frame_err
);
    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t      state_q, state_d;
    logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic        ss_s1_q, ss_s2_q, ss_prev_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic [1:0]  vld_q;
    logic        armed_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_shift_q;
    logic [7:0]  tx_shift_q;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic        miso_q;
    logic        wr_strobe_q;
    logic [6:0]  wr_addr_q;
    logic        frame_err_q;
    logic [7:0]  regs_q [NUM_REGS];

    logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic        byte_done, in_frame, cmd_done, data_done, abort_err;
    logic [2:0]  cnt_after;
    logic [7:0]  rx_byte, rd_data;
    logic [6:0]  addr_next, rd_addr;
    logic        addr_in_range;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_s3_q <= 1'b0;
            ss_s1_q   <= 1'b1; ss_s2_q   <= 1'b1; ss_prev_q <= 1'b1;
            mosi_s1_q <= 1'b0; mosi_s2_q <= 1'b0;
            vld_q     <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            sclk_s1_q <= spi_sclk;  sclk_s2_q <= sclk_s1_q; sclk_s3_q <= sclk_s2_q;
            ss_s1_q   <= spi_ss_n;  ss_s2_q   <= ss_s1_q;   ss_prev_q <= ss_s2_q;
            mosi_s1_q <= spi_mosi;  mosi_s2_q <= mosi_s1_q;
            vld_q     <= {vld_q[0], 1'b1};
            // Only arm once a genuinely sampled high ss_n has passed the synchronizer.
            armed_q   <= armed_q | (vld_q[1] & ss_s2_q);
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign ss_rise   = ss_s2_q & ~ss_prev_q;
    assign ss_fall   = armed_q & ss_prev_q & ~ss_s2_q;
    assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
    assign cnt_after = bit_cnt_q + {2'b00, sclk_rise};
    assign rx_byte   = {rx_shift_q, mosi_s2_q};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = CMD;
            CMD:     if (ss_rise) state_d = IDLE;
                     else if (byte_done) state_d = DATA;
            DATA:    if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_frame  = 1'b0;
        cmd_done  = 1'b0;
        data_done = 1'b0;
        unique case (state_q)
            CMD:     begin in_frame = 1'b1; cmd_done  = byte_done; end
            DATA:    begin in_frame = 1'b1; data_done = byte_done; end
            default: ;
        endcase
    end

    assign abort_err = ss_rise & in_frame & (cnt_after != 3'd0);

`ifdef SPI_SLAVE_AUTOINC_EN
    assign addr_next = addr_q + 7'd1;
`else
    assign addr_next = addr_q;
`endif

    // A command completion reads from the address arriving in that very byte.
    assign rd_addr       = cmd_done ? rx_byte[6:0] : addr_next;
    assign addr_in_range = ({1'b0, addr_q} < NUM_REGS_L);

    always_comb begin
        rd_data = 8'h00;
        if ({1'b0, rd_addr} < NUM_REGS_L) rd_data = regs_q[rd_addr[AW-1:0]];
        else if (rd_addr == 7'h7F)        rd_data = status_in;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= 8'h00;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= abort_err;

            if (!in_frame || ss_rise) bit_cnt_q <= 3'd0;
            else if (sclk_rise)       bit_cnt_q <= bit_cnt_q + 3'd1;

            if (in_frame && sclk_rise) rx_shift_q <= rx_byte[6:0];

            if (!in_frame || ss_rise)       tx_shift_q <= 8'h00;
            else if (cmd_done && rx_byte[7]) tx_shift_q <= rd_data;
            else if (data_done && rw_q)      tx_shift_q <= rd_data;
            else if (sclk_fall)              tx_shift_q <= {tx_shift_q[6:0], 1'b0};

            if (!in_frame || ss_rise) miso_q <= 1'b0;
            else if (sclk_fall)       miso_q <= tx_shift_q[7];

            if (cmd_done) begin
                rw_q   <= rx_byte[7];
                addr_q <= rx_byte[6:0];
            end else if (data_done) begin
                addr_q <= addr_next;
            end

            // Completed bytes commit even when ss_n rises in the same cycle.
            if (data_done && !rw_q && addr_in_range) begin
                regs_q[addr_q[AW-1:0]] <= rx_byte;
                wr_strobe_q            <= 1'b1;
                wr_addr_q              <= addr_q;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[8*gi +: 8] = regs_q[gi];
        end
    endgenerate

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~ss_s2_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign frame_err   = frame_err_q;

endmodule
